gen_test_pulse_ttl: RTL and testbench

Test-pulse generator for the TTL result channel. On every rising edge of the 1 MHz frame reference it emits a burst of N high-then-low pulses on a TTL output. The per-frame edge counter on the receive side counts one falling edge per pulse, so the burst length maps directly onto that counter's value. The block also reports the number of pulses actually sent in the previous frame, so loopback tests can compare sent against received.

---
 rtl/gen_test_pulse_ttl.sv | 195 +++++++++++++++++++
 tb/tb_gen_test_pulse_ttl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gen_test_pulse_ttl.sv
// gen_test_pulse_ttl
// Test-pulse generator for the TTL result channel. Each rising edge of the
// 1 MHz frame reference starts a burst of cnt_pulse_req high-then-low pulses
// on res_ttl_out. The number of falling edges driven in the previous frame is
// reported on cnt_sent, so a loopback test can compare sent against received.
//
// Ports:
//   clk_100Mz      in   system clock, 100 MHz
//   rst            in   asynchronous active-high reset
//   clk_1Mz        in   frame reference, asynchronous, 2-FF synchronised here
//   en             in   generator enable, sampled at the frame strobe
//   cnt_pulse_req  in   pulses requested per frame, latched at the frame strobe
//   res_ttl_out    out  generated TTL pulse train, idles low (registered)
//   busy           out  high while a burst is in progress (registered)
//   cnt_sent       out  falling edges driven in the previous frame
//   frame_err      out  one-cycle pulse when a burst overran its frame
//
// Optional feature, macro GEN_TEST_PULSE_LOOPBACK_EN:
//   res_ttl_loop_in in   loopback of the TTL line, 2-FF synchronised here
//   loop_mismatch   out  at each frame strobe: received count != sent count
module gen_test_pulse_ttl #(
  parameter int PULSE_HIGH = 2,
  parameter int PULSE_LOW  = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk_100Mz,
  input  logic             rst,
  input  logic             clk_1Mz,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt_pulse_req,
`ifdef GEN_TEST_PULSE_LOOPBACK_EN
  input  logic             res_ttl_loop_in,
  output logic             loop_mismatch,
`endif
  output logic             res_ttl_out,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_sent,
  output logic             frame_err
);

  localparam int PH_MAX = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] HI_LAST = PH_W'(PULSE_HIGH - 1);
  localparam logic [PH_W-1:0] LO_LAST = PH_W'(PULSE_LOW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] req_q, req_d;
  logic [CNT_W-1:0] cnt_sent_q, cnt_sent_d;
  logic             frame_err_q, frame_err_d;
  logic             out_q, busy_q;
  logic             sync1_q, sync2_q, sync3_q;
  logic             fs_s;
  logic [CNT_W-1:0] sent_inc_s;

  // Frame reference synchroniser; the third stage feeds the edge detector.
  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= clk_1Mz;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign fs_s = sync2_q & ~sync3_q;

  // Pulse count saturates instead of wrapping.
  assign sent_inc_s = (sent_q == {CNT_W{1'b1}}) ? sent_q : sent_q + CNT_W'(1);

  // Next-state logic: the frame strobe overrides whatever the burst is doing.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    sent_d      = sent_q;
    req_d       = req_q;
    cnt_sent_d  = cnt_sent_q;
    frame_err_d = 1'b0;
    if (fs_s) begin
      // Only completed pulses are in sent_q; a pulse still high is dropped.
      cnt_sent_d  = sent_q;
      sent_d      = {CNT_W{1'b0}};
      frame_err_d = (state_q != S_IDLE);
      ph_d        = {PH_W{1'b0}};
      if (en && (cnt_pulse_req != {CNT_W{1'b0}})) begin
        req_d   = cnt_pulse_req;
        state_d = S_HIGH;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_HIGH: begin
          if (ph_q == HI_LAST) begin
            ph_d   = {PH_W{1'b0}};
            sent_d = sent_inc_s;
            if (sent_inc_s == req_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_LOW;
            end
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
        S_LOW: begin
          if (ph_q == LO_LAST) begin
            ph_d    = {PH_W{1'b0}};
            state_d = S_HIGH;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          ph_d    = {PH_W{1'b0}};
        end
      endcase
    end
  end

  // State, counters and registered outputs (outputs decoded from next state).
  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ph_q        <= {PH_W{1'b0}};
      sent_q      <= {CNT_W{1'b0}};
      req_q       <= {CNT_W{1'b0}};
      cnt_sent_q  <= {CNT_W{1'b0}};
      frame_err_q <= 1'b0;
      out_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      sent_q      <= sent_d;
      req_q       <= req_d;
      cnt_sent_q  <= cnt_sent_d;
      frame_err_q <= frame_err_d;
      out_q       <= (state_d == S_HIGH);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign res_ttl_out = out_q;
  assign busy        = busy_q;
  assign cnt_sent    = cnt_sent_q;
  assign frame_err   = frame_err_q;

`ifdef GEN_TEST_PULSE_LOOPBACK_EN
  logic             lsync1_q, lsync2_q, lsync3_q;
  logic [CNT_W-1:0] loop_cnt_q;
  logic             loop_mismatch_q;
  logic             lfall_s;

  assign lfall_s = lsync3_q & ~lsync2_q;

  // Loopback synchroniser, per-frame falling-edge counter and comparison.
  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      lsync1_q        <= 1'b0;
      lsync2_q        <= 1'b0;
      lsync3_q        <= 1'b0;
      loop_cnt_q      <= {CNT_W{1'b0}};
      loop_mismatch_q <= 1'b0;
    end else begin
      lsync1_q <= res_ttl_loop_in;
      lsync2_q <= lsync1_q;
      lsync3_q <= lsync2_q;
      if (fs_s) begin
        loop_mismatch_q <= (loop_cnt_q != sent_q);
        loop_cnt_q      <= {CNT_W{1'b0}};
      end else if (lfall_s && (loop_cnt_q != {CNT_W{1'b1}})) begin
        loop_cnt_q <= loop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign loop_mismatch = loop_mismatch_q;
`endif

endmodule

// File: tb/tb_gen_test_pulse_ttl.sv
// Directed bench for gen_test_pulse_ttl with default parameters.
// Edge numbering: e=0 is the clock edge at which a frame's clk_1Mz high is
// first sampled; the frame reference has a 100-cycle period, so every frame
// burst starts at edge 100*n+2.
module tb_gen_test_pulse_ttl;
  logic       clk_100Mz;
  logic       rst;
  logic       clk_1Mz;
  logic       en;
  logic [7:0] cnt_pulse_req;
  logic       res_ttl_out;
  logic       busy;
  logic [7:0] cnt_sent;
  logic       frame_err;
`ifdef GEN_TEST_PULSE_LOOPBACK_EN
  logic       loop_force;
  logic       res_ttl_loop_in;
  logic       loop_mismatch;
  assign res_ttl_loop_in = loop_force ? 1'b0 : res_ttl_out;
`endif

  int  n_checks;
  int  n_pass;
  int  e;
  bit  frame_on;
  bit  seen_hi;

  gen_test_pulse_ttl dut (
    .clk_100Mz     (clk_100Mz),
    .rst           (rst),
    .clk_1Mz       (clk_1Mz),
    .en            (en),
    .cnt_pulse_req (cnt_pulse_req),
`ifdef GEN_TEST_PULSE_LOOPBACK_EN
    .res_ttl_loop_in (res_ttl_loop_in),
    .loop_mismatch   (loop_mismatch),
`endif
    .res_ttl_out   (res_ttl_out),
    .busy          (busy),
    .cnt_sent      (cnt_sent),
    .frame_err     (frame_err)
  );

  initial clk_100Mz = 1'b0;
  always #5 clk_100Mz = ~clk_100Mz;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at e=%0d: got %0d, expected %0d", tag, e, obs, exp);
    end
  endtask

  // Drive clk_1Mz for the next edge, take that edge, sample 1 ns later.
  task automatic step();
    @(negedge clk_100Mz);
    clk_1Mz = frame_on && (((e + 1) % 100) < 50);
    @(posedge clk_100Mz);
    e++;
    #1;
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; clk_1Mz = 1'b0; en = 1'b0; cnt_pulse_req = 8'd0;
    frame_on = 1'b0; e = -100;
`ifdef GEN_TEST_PULSE_LOOPBACK_EN
    loop_force = 1'b0;
`endif
    repeat (3) step();
    check_eq("rst_out",   res_ttl_out, 0);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_sent",  cnt_sent, 0);
    check_eq("rst_ferr",  frame_err, 0);
    rst = 1'b0;
    repeat (3) step();

    // Burst of 3 in frame 0
    en = 1'b1; cnt_pulse_req = 8'd3;
    e = -1; frame_on = 1'b1;
    run_to(1);   check_eq("b3_out_k1", res_ttl_out, 0);
    run_to(2);   check_eq("b3_out_k2", res_ttl_out, 1);
                 check_eq("b3_busy_k2", busy, 1);
    run_to(3);   check_eq("b3_out_k3", res_ttl_out, 1);
    run_to(4);   check_eq("b3_out_k4", res_ttl_out, 0);
    run_to(6);   check_eq("b3_out_k6", res_ttl_out, 1);
    run_to(11);  check_eq("b3_out_k11", res_ttl_out, 1);
                 check_eq("b3_busy_k11", busy, 1);
    run_to(12);  check_eq("b3_out_k12", res_ttl_out, 0);
                 check_eq("b3_busy_k12", busy, 0);
    run_to(101); check_eq("b3_sent_pre", cnt_sent, 0);
    run_to(102); check_eq("b3_sent", cnt_sent, 3);
                 check_eq("b3_ferr", frame_err, 0);
                 check_eq("f1_out_start", res_ttl_out, 1);

    // Request change mid-burst: this frame still sends 3, the next sends 7
    run_to(104); cnt_pulse_req = 8'd7;
    run_to(111); check_eq("chg_out_111", res_ttl_out, 1);
    run_to(112); check_eq("chg_busy_112", busy, 0);
    run_to(202); check_eq("chg_sent_f1", cnt_sent, 3);
    run_to(227); check_eq("chg_out_227", res_ttl_out, 1);
    run_to(228); check_eq("chg_out_228", res_ttl_out, 0);
                 check_eq("chg_busy_228", busy, 0);

    // Overrun: req=30 leaves 25 falling edges in a 100-cycle frame
    run_to(250); cnt_pulse_req = 8'd30;
    run_to(302); check_eq("chg_sent_f2", cnt_sent, 7);
    run_to(399); check_eq("ovr_out_399", res_ttl_out, 1);
    run_to(400); check_eq("ovr_out_400", res_ttl_out, 0);
                 check_eq("ovr_busy_400", busy, 1);
    run_to(401); check_eq("ovr_ferr_401", frame_err, 0);
    run_to(402); check_eq("ovr_ferr", frame_err, 1);
                 check_eq("ovr_sent", cnt_sent, 25);
                 check_eq("ovr_restart", res_ttl_out, 1);
    run_to(403); check_eq("ovr_ferr_1cyc", frame_err, 0);

    // req=0 then en=0: overrun ends the running burst, nothing new starts
    run_to(450); cnt_pulse_req = 8'd0;
    run_to(502); check_eq("r0_ferr", frame_err, 1);
                 check_eq("r0_sent", cnt_sent, 25);
                 check_eq("r0_out", res_ttl_out, 0);
                 check_eq("r0_busy", busy, 0);
    seen_hi = 1'b0;
    while (e < 701) begin
      step();
      if (e == 550) begin
        en = 1'b0; cnt_pulse_req = 8'd5;
      end
      if (res_ttl_out || busy) seen_hi = 1'b1;
      if (e == 602) check_eq("r0_sent_f6", cnt_sent, 0);
    end
    check_eq("idle_quiet", seen_hi, 0);
    run_to(702); check_eq("en0_sent", cnt_sent, 0);
                 check_eq("en0_out", res_ttl_out, 0);

    // Reset mid-pulse
    run_to(750); en = 1'b1; cnt_pulse_req = 8'd3;
    run_to(902); check_eq("pre_rst_sent", cnt_sent, 3);
    run_to(903); check_eq("pre_rst_out", res_ttl_out, 1);
    rst = 1'b1;
    #1;
    check_eq("arst_out",  res_ttl_out, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_sent", cnt_sent, 0);
    check_eq("arst_ferr", frame_err, 0);
    run_to(960); rst = 1'b0;
    seen_hi = 1'b0;
    while (e < 1001) begin
      step();
      if (e == 970) cnt_pulse_req = 8'd4;
      if (res_ttl_out || busy) seen_hi = 1'b1;
    end
    check_eq("post_rst_quiet", seen_hi, 0);
    run_to(1002); check_eq("post_rst_out", res_ttl_out, 1);
                  check_eq("post_rst_sent", cnt_sent, 0);
    run_to(1102); check_eq("b4_sent", cnt_sent, 4);
`ifdef GEN_TEST_PULSE_LOOPBACK_EN
    check_eq("loop_match", loop_mismatch, 0);
    run_to(1103); loop_force = 1'b1;
    run_to(1202); check_eq("loop_mismatch", loop_mismatch, 1);
`endif
    run_to(1210);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
